nios2_fp_multitimer: RTL
========================

# nios2_fp_multitimer

Parametrised multi-channel interval timer for the Nios II fixed-point system, the successor to the single-channel 16-bit-bus timer. Each of `NUM_CH` independent down-counters has its own period, prescaler, mode bits, snapshot and timeout flag. All channels share one 32-bit Avalon-MM slave with registered read data. Per-channel interrupts are exposed as a vector and as a single OR-reduced `irq`.

## Interface
- `NUM_CH`, 2: number of channels, 1..4.
- `CNT_W`, 32: counter/period width, 8..32.
- `PRE_W`, 8: prescaler width, 1..8.
- `DEFAULT_PERIOD`, 49999: reset value of every period register and counter.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `address`  in  4  {channel[1:0], reg[1:0]}.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data; reset 0.
- `irq`  out  1  OR of `irq_vec`; reset 0.
- `irq_vec`  out  NUM_CH  per-channel interrupt, `TO & ITO`; reset 0.
- `tick_pulse`  out  NUM_CH  one-cycle pulse per channel timeout; reset 0.

## Operation
- Write strobe: `chipselect & ~write_n`. Channel index ≥ NUM_CH: writes ignored, reads return 0.
- reg 0 STATUS: read {30'b0, RUN, TO}. Any write clears TO.
- reg 1 CONTROL: bits [0] ITO, [1] CONT, [15:8] PRESCALE (upper bits above PRE_W read 0). Bits [2] START and [3] STOP are strobes and are not stored; they read 0. Bit 2 set → RUN=1. Bit 3 set → RUN=0. Both set → START wins.
- reg 2 PERIOD: write stores `writedata[CNT_W-1:0]`. Read is zero-extended.
- reg 3 SNAPSHOT: any write captures the live counter. Read returns the captured value, zero-extended.
- Period write sets `force_reload` for 1 cycle. That cycle: counter ← period, prescaler ← PRESCALE, RUN ← 0.
- Prescaler: while RUN, it counts down. At 0 it produces `tick` and reloads PRESCALE. PRESCALE=0 → tick every cycle.
- On a tick with counter ≠ 0: counter decrements by 1.
- On a tick with counter = 0 (timeout):
  - counter ← period;
  - TO ← 1;
  - `tick_pulse` high for 1 cycle;
  - if CONT=0, RUN ← 0.
- Timeout interval: (period+1)·(PRESCALE+1) clocks.
- Period 0 with CONT=1: timeout on every tick.
- START while running: prescaler and counter are not reloaded; RUN stays 1.
- STOP freezes the counter and prescaler at their current values.
- Channels are fully independent. No shared state except the bus and `readdata`.

## Timing
- Register writes take effect at the clock edge of the write cycle. A flag set by a write is visible in a read 1 cycle later.
- `readdata` = mux of the current `address`, registered every cycle regardless of `chipselect`. Latency is 1 clock, with no wait states.
- START written at edge N: RUN=1 after N. The first decrement occurs at edge N+1+PRESCALE.
- TO is set at the edge of the timeout tick. `irq_vec` is combinational from TO/ITO, so it is high in the same cycle TO reads 1.
- STATUS write and timeout in the same cycle: TO=1 (set wins; no event lost).
- Period write and timeout in the same cycle: the reload uses the new `writedata` value, RUN=0, and TO is still set.
- Snapshot write in the same cycle as a decrement: captures the pre-decrement value.
- `reset_n` low at any time: all state returns asynchronously to its reset values.
  - counters and periods = DEFAULT_PERIOD;
  - control, TO, RUN, snapshots, prescalers, `readdata` = 0.

## Test plan
- Reset values:
  - after reset, read ch0 PERIOD → 49999;
  - read STATUS → 0; `irq`=0 and `tick_pulse`=0.
- One-shot timeout:
  - ch0: PERIOD=9, CONTROL=0x05 (ITO|START);
  - `tick_pulse[0]` fires exactly 10 clocks after the RUN edge, then `irq`=1;
  - STATUS reads 0x1 (RUN=0);
  - STATUS write → `irq`=0 next cycle.
- Continuous with prescaler:
  - ch1: PERIOD=3, CONTROL=0x0306 (PRESCALE=3, CONT, START);
  - `tick_pulse[1]` every 16 clocks for ≥5 periods; ch0 is unaffected.
- Simultaneous events:
  - STATUS clear issued on the exact timeout cycle → TO stays 1;
  - CONTROL=0x0C (START and STOP together) → RUN=1.
- Period write mid-run:
  - ch0 running with PERIOD=100; write PERIOD=20;
  - RUN=0 next cycle, and the snapshot then reads 20.
- Snapshot and out-of-range access:
  - snapshot during a run matches the expected count;
  - with NUM_CH=2, accesses at address 0xB read 0, and writes there change nothing.
  - Reset asserted mid-count → all registers return to their reset values immediately.

Source files
------------

// File: rtl/nios2_fp_multitimer.sv
// Multi-channel interval timer: NUM_CH independent prescaled down-counters
// behind one 32-bit Avalon-MM slave with registered read data.
module nios2_fp_multitimer #(
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 32,
    parameter int PRE_W          = 8,
    parameter int DEFAULT_PERIOD = 49999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec,
    output logic [NUM_CH-1:0] tick_pulse
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

    logic [NUM_CH-1:0][CNT_W-1:0] period_r, counter_r, snap_r;
    logic [NUM_CH-1:0][PRE_W-1:0] pre_r, prescale_r;
    logic [NUM_CH-1:0]            ito_r, cont_r, run_r, to_r;

    logic [NUM_CH-1:0]            tick_s, timeout_s;
    logic [NUM_CH-1:0]            st_wr_s, ct_wr_s, pe_wr_s, sn_wr_s;
    logic [NUM_CH-1:0][31:0]      ch_word_s;
    logic                         wr_s, start_s, stop_s;
    logic [1:0]                   reg_s;
    logic [PRE_W-1:0]             wr_pre_s;
    logic [31:0]                  rd_s;

    assign wr_s     = chipselect & ~write_n;
    assign reg_s    = address[1:0];
    assign start_s  = writedata[2];
    assign stop_s   = writedata[3];
    assign wr_pre_s = writedata[8 +: PRE_W];

    // Per-channel tick/timeout detection and register write strobes
    always_comb begin
        tick_s    = '0;
        timeout_s = '0;
        st_wr_s   = '0;
        ct_wr_s   = '0;
        pe_wr_s   = '0;
        sn_wr_s   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tick_s[i]    = run_r[i] && (pre_r[i] == PRE_W'(0));
            timeout_s[i] = tick_s[i] && (counter_r[i] == CNT_W'(0));
            st_wr_s[i]   = wr_s && (address[3:2] == 2'(i)) && (reg_s == 2'd0);
            ct_wr_s[i]   = wr_s && (address[3:2] == 2'(i)) && (reg_s == 2'd1);
            pe_wr_s[i]   = wr_s && (address[3:2] == 2'(i)) && (reg_s == 2'd2);
            sn_wr_s[i]   = wr_s && (address[3:2] == 2'(i)) && (reg_s == 2'd3);
        end
    end

    // Read mux; unpopulated channel slots fall through as zero
    always_comb begin
        rd_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_word_s[i] = 32'd0;
            case (reg_s)
                2'd0: ch_word_s[i][1:0] = {run_r[i], to_r[i]};
                2'd1: begin
                    ch_word_s[i][8 +: PRE_W] = prescale_r[i];
                    ch_word_s[i][1]          = cont_r[i];
                    ch_word_s[i][0]          = ito_r[i];
                end
                2'd2:    ch_word_s[i][CNT_W-1:0] = period_r[i];
                2'd3:    ch_word_s[i][CNT_W-1:0] = snap_r[i];
                default: ch_word_s[i] = 32'd0;
            endcase
            rd_s = rd_s | ((address[3:2] == 2'(i)) ? ch_word_s[i] : 32'd0);
        end
    end

    // Channel state: a timeout always sets TO even when the same cycle clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_r   <= {NUM_CH{DEF_P}};
            counter_r  <= {NUM_CH{DEF_P}};
            snap_r     <= '0;
            pre_r      <= '0;
            prescale_r <= '0;
            ito_r      <= '0;
            cont_r     <= '0;
            run_r      <= '0;
            to_r       <= '0;
            tick_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                tick_pulse[i] <= timeout_s[i];
                if (timeout_s[i]) begin
                    to_r[i] <= 1'b1;
                end else if (st_wr_s[i]) begin
                    to_r[i] <= 1'b0;
                end
                if (sn_wr_s[i]) begin
                    snap_r[i] <= counter_r[i];
                end
                if (ct_wr_s[i]) begin
                    ito_r[i]      <= writedata[0];
                    cont_r[i]     <= writedata[1];
                    prescale_r[i] <= wr_pre_s;
                end
                if (pe_wr_s[i]) begin
                    period_r[i]  <= writedata[CNT_W-1:0];
                    counter_r[i] <= writedata[CNT_W-1:0];
                    pre_r[i]     <= prescale_r[i];
                    run_r[i]     <= 1'b0;
                end else begin
                    if (timeout_s[i]) begin
                        counter_r[i] <= period_r[i];
                    end else if (tick_s[i]) begin
                        counter_r[i] <= counter_r[i] - CNT_W'(1);
                    end
                    // A fresh START reloads the prescaler; START while running does not
                    if (ct_wr_s[i] && start_s && !run_r[i]) begin
                        pre_r[i] <= wr_pre_s;
                    end else if (tick_s[i]) begin
                        pre_r[i] <= prescale_r[i];
                    end else if (run_r[i]) begin
                        pre_r[i] <= pre_r[i] - PRE_W'(1);
                    end
                    if (ct_wr_s[i] && start_s) begin
                        run_r[i] <= 1'b1;
                    end else if (ct_wr_s[i] && stop_s) begin
                        run_r[i] <= 1'b0;
                    end else if (timeout_s[i] && !cont_r[i]) begin
                        run_r[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Registered read data, sampled every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            readdata <= rd_s;
        end
    end

    assign irq_vec = to_r & ito_r;
    assign irq     = |irq_vec;

endmodule
